// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle ARM main control FSM.
// Holds state, Op, cmd and datapath select encodings plus a small helper.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // C/V flags are only meaningful for ADD/SUB results
    function automatic logic is_arith(input logic [1:0] alu_ctl);
        return (alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB);
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Instruction-field and control bundle between main FSM and datapath.
// Optional InstrCount signal present when MCFSM_INSTR_CNT_EN is defined.
interface multicycle_main_fsm_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic [1:0] FlagW;
    logic       NoWrite;
    logic [1:0] ALUControl;
`ifdef MCFSM_INSTR_CNT_EN
    logic [31:0] InstrCount;
`endif

    modport master (
        input  Op, Funct, Rd,
`ifdef MCFSM_INSTR_CNT_EN
        output InstrCount,
`endif
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output NextPC, PCS, RegW, MemW, FlagW, NoWrite, ALUControl
    );

    modport slave (
        output Op, Funct, Rd,
`ifdef MCFSM_INSTR_CNT_EN
        input  InstrCount,
`endif
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  NextPC, PCS, RegW, MemW, FlagW, NoWrite, ALUControl
    );

endinterface

// File: rtl/multicycle_alu_decoder.sv
// ALU decoder: maps ALUOp and Funct cmd/S to ALUControl, FlagW, NoWrite.
// Purely combinational.
module multicycle_alu_decoder
    import multicycle_pkg::*;
(
    input  logic       i_alu_op,
    input  logic [3:0] i_cmd,
    input  logic       i_s,
    output logic [1:0] o_alu_control,
    output logic [1:0] o_flag_w,
    output logic       o_no_write
);

    // Select ALU operation and flag-write requests from the cmd field
    always_comb begin
        o_alu_control = ALU_ADD;
        o_flag_w      = 2'b00;
        o_no_write    = 1'b0;
        if (i_alu_op) begin
            case (i_cmd)
                CMD_ADD: o_alu_control = ALU_ADD;
                CMD_SUB: o_alu_control = ALU_SUB;
                CMD_AND: o_alu_control = ALU_AND;
                CMD_ORR: o_alu_control = ALU_ORR;
                CMD_CMP: begin
                    o_alu_control = ALU_SUB;
                    o_no_write    = 1'b1;
                end
                default: o_alu_control = ALU_ADD;
            endcase
            o_flag_w = {i_s, i_s & is_arith(o_alu_control)};
        end
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle ARM core (Moore, one state per cycle).
// Optional MCFSM_INSTR_CNT_EN adds a retired-instruction counter.
module multicycle_main_fsm
    import multicycle_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_main_fsm_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic       w_irwrite;
    logic       w_adr_src;
    logic       w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_res_src;
    logic       w_next_pc;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_branch;
    logic       w_alu_op;
    logic [1:0] w_alu_ctl;
    logic [1:0] w_flag_w;
    logic       w_dec_no_write;
    logic       w_wb_no_write;
    logic       w_pcs;

    // State register; reset restarts at FETCH and drops any partial instruction
    always_ff @(posedge clk) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    // Next-state sequencing from Op/Funct
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_MEM:  w_next = MEMADR;
                    OP_DP:   w_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   w_next = BRANCH;
                    default: w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    w_next = MEMWB;
            EXECUTER: w_next = ALUWB;
            EXECUTEI: w_next = ALUWB;
            default:  w_next = FETCH;
        endcase
    end

    // Moore outputs per state; anything not set stays 0
    always_comb begin
        w_irwrite = 1'b0;
        w_adr_src = 1'b0;
        w_src_a   = 1'b0;
        w_src_b   = SRCB_RD2;
        w_res_src = RES_ALUOUT;
        w_next_pc = 1'b0;
        w_reg_w   = 1'b0;
        w_mem_w   = 1'b0;
        w_branch  = 1'b0;
        w_alu_op  = 1'b0;
        case (r_state)
            FETCH: begin
                w_irwrite = 1'b1;
                w_src_a   = 1'b1;
                w_src_b   = SRCB_FOUR;
                w_res_src = RES_ALU;
                w_next_pc = 1'b1;
            end
            DECODE: begin
                w_src_a   = 1'b1;
                w_src_b   = SRCB_FOUR;
                w_res_src = RES_ALU;
            end
            MEMADR: w_src_b = SRCB_IMM;
            MEMRD:  w_adr_src = 1'b1;
            MEMWB: begin
                w_res_src = RES_DATA;
                w_reg_w   = 1'b1;
            end
            MEMWR: begin
                w_adr_src = 1'b1;
                w_mem_w   = 1'b1;
            end
            EXECUTER: w_alu_op = 1'b1;
            EXECUTEI: begin
                w_src_b  = SRCB_IMM;
                w_alu_op = 1'b1;
            end
            ALUWB: w_reg_w = 1'b1;
            BRANCH: begin
                w_src_b   = SRCB_IMM;
                w_res_src = RES_ALU;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    multicycle_alu_decoder u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_cmd         (bus.Funct[4:1]),
        .i_s           (bus.Funct[0]),
        .o_alu_control (w_alu_ctl),
        .o_flag_w      (w_flag_w),
        .o_no_write    (w_dec_no_write)
    );

    // CMP must keep NoWrite high in ALUWB, where ALUOp is already 0
    assign w_wb_no_write = (r_state == ALUWB) && (bus.Funct[4:1] == CMD_CMP);
    assign w_pcs = w_branch | (w_reg_w & (bus.Rd == 4'hF));

    assign bus.IRWrite    = ~reset & w_irwrite;
    assign bus.AdrSrc     = ~reset & w_adr_src;
    assign bus.ALUSrcA    = ~reset & w_src_a;
    assign bus.ALUSrcB    = reset ? 2'b00 : w_src_b;
    assign bus.ResultSrc  = reset ? 2'b00 : w_res_src;
    assign bus.NextPC     = ~reset & w_next_pc;
    assign bus.PCS        = ~reset & w_pcs;
    assign bus.RegW       = ~reset & w_reg_w;
    assign bus.MemW       = ~reset & w_mem_w;
    assign bus.FlagW      = reset ? 2'b00 : w_flag_w;
    assign bus.NoWrite    = ~reset & (w_dec_no_write | w_wb_no_write);
    assign bus.ALUControl = reset ? 2'b00 : w_alu_ctl;

`ifdef MCFSM_INSTR_CNT_EN
    logic [31:0] r_instr_count;

    // Count instructions retiring back into FETCH; wraps naturally
    always_ff @(posedge clk) begin
        if (reset)
            r_instr_count <= 32'd0;
        else if (w_next == FETCH && r_state != FETCH)
            r_instr_count <= r_instr_count + 32'd1;
    end

    assign bus.InstrCount = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed table, random
// instructions against a step-based reference model, reset/counter cases.
module tb_multicycle_main_fsm;

    typedef struct packed {
        logic       irw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       nextpc;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic [1:0] flagw;
        logic       nowrite;
        logic [1:0] aluctl;
    } ctl_t;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        int         lat;
        logic [1:0] ex_aluctl;
        logic [1:0] ex_flagw;
        logic       last_regw;
        logic       last_memw;
        logic       last_pcs;
        logic       last_nowrite;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;
    ctl_t cap [5];

    multicycle_main_fsm_if bus_if ();

    multicycle_main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic ctl_t sample();
        ctl_t c;
        c.irw     = bus_if.IRWrite;
        c.adr     = bus_if.AdrSrc;
        c.srca    = bus_if.ALUSrcA;
        c.srcb    = bus_if.ALUSrcB;
        c.res     = bus_if.ResultSrc;
        c.nextpc  = bus_if.NextPC;
        c.pcs     = bus_if.PCS;
        c.regw    = bus_if.RegW;
        c.memw    = bus_if.MemW;
        c.flagw   = bus_if.FlagW;
        c.nowrite = bus_if.NoWrite;
        c.aluctl  = bus_if.ALUControl;
        return c;
    endfunction

    function automatic int latency(logic [1:0] op, logic [5:0] f);
        if (op == 2'b11) return 2;
        if (op == 2'b10) return 3;
        if (op == 2'b01) return f[0] ? 5 : 4;
        return 4;
    endfunction

    function automatic logic [1:0] alu_of(logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction, by instruction class
    function automatic ctl_t model(logic [1:0] op, logic [5:0] f,
                                   logic [3:0] rd, int k);
        ctl_t e;
        logic cmp;
        e   = '0;
        cmp = (f[4:1] == 4'b1010);
        if (k == 0) begin
            e.irw = 1; e.srca = 1; e.srcb = 2; e.res = 2; e.nextpc = 1;
        end else if (k == 1) begin
            e.srca = 1; e.srcb = 2; e.res = 2;
        end else if (op == 2'b00) begin
            if (k == 2) begin
                e.srcb    = f[5] ? 2'd1 : 2'd0;
                e.aluctl  = alu_of(f[4:1]);
                e.flagw   = {f[0], f[0] & (e.aluctl < 2)};
                e.nowrite = cmp;
            end else begin
                e.regw = 1; e.nowrite = cmp; e.pcs = (rd == 15);
            end
        end else if (op == 2'b01) begin
            if (k == 2) e.srcb = 1;
            else if (f[0] && k == 3) e.adr = 1;
            else if (f[0]) begin
                e.res = 1; e.regw = 1; e.pcs = (rd == 15);
            end else begin
                e.adr = 1; e.memw = 1;
            end
        end else if (op == 2'b10) begin
            e.srcb = 1; e.res = 2; e.pcs = 1;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(string name, ctl_t act, ctl_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_cnt(string name);
`ifdef MCFSM_INSTR_CNT_EN
        chk(name, bus_if.InstrCount, exp_cnt);
`else
        if (name == "") $display("unused");
`endif
    endtask

    // Called just after a negedge with the FSM in FETCH
    task automatic run_instr(string tag, logic [1:0] op,
                             logic [5:0] f, logic [3:0] rd);
        int lat;
        bus_if.Op    = op;
        bus_if.Funct = f;
        bus_if.Rd    = rd;
        lat = latency(op, f);
        for (int k = 0; k < lat; k++) begin
            #1;
            cap[k] = sample();
            chk_ctl($sformatf("%s step%0d", tag, k), cap[k],
                    model(op, f, rd, k));
            @(negedge clk);
        end
        exp_cnt++;
        #1;
        chk_cnt({tag, " count"});
    endtask

    vec_t vt [10];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        reset        = 1'b1;
        bus_if.Op    = 2'b00;
        bus_if.Funct = 6'd0;
        bus_if.Rd    = 4'd0;

        vt[0] = '{"ADD",   2'b00, 6'b001000, 4'd3,  4, 2'b00, 2'b00, 1, 0, 0, 0};
        vt[1] = '{"LDR",   2'b01, 6'b011001, 4'd2,  5, 2'b00, 2'b00, 1, 0, 0, 0};
        vt[2] = '{"STR",   2'b01, 6'b011000, 4'd2,  4, 2'b00, 2'b00, 0, 1, 0, 0};
        vt[3] = '{"B",     2'b10, 6'b100000, 4'd0,  3, 2'b00, 2'b00, 0, 0, 1, 0};
        vt[4] = '{"ADDPC", 2'b00, 6'b001000, 4'd15, 4, 2'b00, 2'b00, 1, 0, 1, 0};
        vt[5] = '{"CMP",   2'b00, 6'b010101, 4'd0,  4, 2'b01, 2'b11, 1, 0, 0, 1};
        vt[6] = '{"ANDS",  2'b00, 6'b000001, 4'd1,  4, 2'b10, 2'b10, 1, 0, 0, 0};
        vt[7] = '{"ORRI",  2'b00, 6'b111000, 4'd4,  4, 2'b11, 2'b00, 1, 0, 0, 0};
        vt[8] = '{"SUBS",  2'b00, 6'b000101, 4'd5,  4, 2'b01, 2'b11, 1, 0, 0, 0};
        vt[9] = '{"UNDEF", 2'b11, 6'b000000, 4'd15, 2, 2'b00, 2'b00, 0, 0, 0, 0};

        repeat (2) @(negedge clk);
        #1;
        chk_ctl("reset outputs", sample(), '0);
        chk_cnt("reset count");
        reset = 1'b0;

        foreach (vt[i]) begin
            run_instr(vt[i].name, vt[i].op, vt[i].funct, vt[i].rd);
            chk({vt[i].name, " back-to-fetch"}, bus_if.IRWrite, 1);
            chk({vt[i].name, " last-irw"}, cap[vt[i].lat-1].irw, 0);
            chk({vt[i].name, " last-regw"}, cap[vt[i].lat-1].regw,
                vt[i].last_regw);
            chk({vt[i].name, " last-memw"}, cap[vt[i].lat-1].memw,
                vt[i].last_memw);
            chk({vt[i].name, " last-pcs"}, cap[vt[i].lat-1].pcs,
                vt[i].last_pcs);
            chk({vt[i].name, " last-nowrite"}, cap[vt[i].lat-1].nowrite,
                vt[i].last_nowrite);
            if (vt[i].lat > 2) begin
                chk({vt[i].name, " ex-aluctl"}, cap[2].aluctl,
                    vt[i].ex_aluctl);
                chk({vt[i].name, " ex-flagw"}, cap[2].flagw,
                    vt[i].ex_flagw);
            end
        end

        for (int n = 0; n < 200; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            logic [3:0] cmds [5];
            cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if ($urandom_range(0, 1) == 1)
                f[4:1] = cmds[$urandom_range(0, 4)];
            rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            run_instr($sformatf("rnd%0d", n), op, f, rd);
        end

        // Reset in MEMRD of an LDR: partial load discarded, no RegW
        bus_if.Op    = 2'b01;
        bus_if.Funct = 6'b011001;
        bus_if.Rd    = 4'd7;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk_ctl($sformatf("abort step%0d", k), sample(),
                    model(2'b01, 6'b011001, 4'd7, k));
            if (k < 3) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk_ctl("reset in MEMRD", sample(), '0);
        @(negedge clk);
        #1;
        chk_ctl("reset held", sample(), '0);
        exp_cnt = 0;
        chk_cnt("count after reset");
        @(negedge clk);
        reset = 1'b0;
        run_instr("post-reset ADD", 2'b00, 6'b001000, 4'd3);
        run_instr("post-reset STR", 2'b01, 6'b011000, 4'd1);
        run_instr("post-reset B",   2'b10, 6'b000000, 4'd0);
`ifdef MCFSM_INSTR_CNT_EN
        chk("count ADD,STR,B", bus_if.InstrCount, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
